// File: rtl/ps2_key_tracker_pkg.sv
// Shared constants and types for the PS/2 scancode-set-2 key tracker.
package ps2_pkg;

  // Protocol prefix and status bytes
  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_OVF0   = 8'h00;
  localparam logic [7:0] PS2_OVF1   = 8'hFF;

  // Set-2 make codes for the usual game keys
  localparam logic [7:0] KEY_W     = 8'h1D;
  localparam logic [7:0] KEY_A     = 8'h1C;
  localparam logic [7:0] KEY_S     = 8'h1B;
  localparam logic [7:0] KEY_D     = 8'h23;
  localparam logic [7:0] KEY_P     = 8'h4D;
  localparam logic [7:0] KEY_SPACE = 8'h29;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } seq_state_t;

  // Keyboard status replies that carry no key information
  function automatic logic is_status_byte(input logic [7:0] b);
    return (b == PS2_ACK) || (b == PS2_BAT) || (b == PS2_ECHO) || (b == PS2_RESEND);
  endfunction

  function automatic logic is_overflow_byte(input logic [7:0] b);
    return (b == PS2_OVF0) || (b == PS2_OVF1);
  endfunction

endpackage

// File: rtl/ps2_key_tracker_if.sv
// Byte stream in from the PS/2 controller, key state out to game logic.
interface ps2_key_if #(
  parameter int NUM_KEYS = 4
);
  logic [7:0]          received_data;
  logic                received_data_en;
  logic [NUM_KEYS-1:0] key_held;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic                any_held;
  logic [7:0]          last_code;
  logic                last_ext;
  logic                last_break;
  logic                seq_error;

  modport master (
    output received_data, received_data_en,
    input  key_held, key_press, key_release, any_held,
    input  last_code, last_ext, last_break, seq_error
  );

  modport slave (
    input  received_data, received_data_en,
    output key_held, key_press, key_release, any_held,
    output last_code, last_ext, last_break, seq_error
  );
endinterface

// File: rtl/ps2_key_tracker_seq_decoder.sv
// Prefix sequencer: turns the raw byte stream into completed codes with
// ext/break flags. Outputs are combinational for the current byte so the
// top level can register everything in a single stage.
//
// state      | meaning
// -----------+------------------------------------------
// ST_IDLE    | waiting for a prefix or a plain make code
// ST_EXT     | E0 seen, next code is an extended make
// ST_BRK     | F0 seen, next code is a break
// ST_EXT_BRK | E0 F0 seen, next code is an extended break
module ps2_seq_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       data_en,
  output logic       code_valid,
  output logic [7:0] code,
  output logic       is_ext,
  output logic       is_break,
  output logic       overflow,
  output logic       seq_error
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  seq_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  assign code = data;

  // State and timeout counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state and per-byte decode; a byte arriving on the expiry cycle wins
  always_comb begin
    state_nxt  = state;
    code_valid = 1'b0;
    is_ext     = 1'b0;
    is_break   = 1'b0;
    overflow   = 1'b0;
    seq_error  = 1'b0;
    if (data_en) begin
      case (state)
        ST_IDLE: begin
          if (data == PS2_EXT) begin
            state_nxt = ST_EXT;
          end else if (data == PS2_BRK) begin
            state_nxt = ST_BRK;
          end else if (!is_status_byte(data)) begin
            if (is_overflow_byte(data)) overflow = 1'b1;
            else                        code_valid = 1'b1;
          end
        end
        ST_EXT: begin
          if (data == PS2_EXT) begin
            seq_error = 1'b1;
          end else if (data == PS2_BRK) begin
            state_nxt = ST_EXT_BRK;
          end else begin
            code_valid = 1'b1;
            is_ext     = 1'b1;
            state_nxt  = ST_IDLE;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          if (data == PS2_EXT) begin
            seq_error = 1'b1;
            state_nxt = ST_EXT;
          end else if (data == PS2_BRK) begin
            seq_error = 1'b1;
          end else begin
            code_valid = 1'b1;
            is_break   = 1'b1;
            is_ext     = (state == ST_EXT_BRK);
            state_nxt  = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end else if ((state != ST_IDLE) && (cnt == CNT_LAST)) begin
      state_nxt = ST_IDLE;
      seq_error = 1'b1;
    end
  end

  // Gap counter only runs while a prefix is pending
  always_comb begin
    if (data_en || (state_nxt == ST_IDLE)) cnt_nxt = '0;
    else                                   cnt_nxt = cnt + 1'b1;
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// Key tracker top: matches completed codes against the key table, keeps the
// held state per key and generates one-cycle press/release pulses.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int                    NUM_KEYS       = 4,
  parameter logic [NUM_KEYS*8-1:0] KEY_CODES      = {KEY_SPACE, KEY_P, KEY_S, KEY_W},
  parameter logic [NUM_KEYS-1:0]   KEY_EXT        = '0,
  parameter int                    TIMEOUT_CYCLES = 1_000_000
) (
  input logic     CLOCK_50,
  input logic     reset,
  ps2_key_if.slave bus
);

  logic                code_valid;
  logic [7:0]          dec_code;
  logic                dec_ext;
  logic                dec_break;
  logic                overflow;
  logic                dec_error;

  logic [NUM_KEYS-1:0] match;
  logic [NUM_KEYS-1:0] held_q, held_nxt;
  logic [NUM_KEYS-1:0] press_q, press_nxt;
  logic [NUM_KEYS-1:0] release_q, release_nxt;
  logic [7:0]          last_code_q;
  logic                last_ext_q;
  logic                last_break_q;
  logic                seq_error_q;

  ps2_seq_decoder #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_seq (
    .clk       (CLOCK_50),
    .rst       (reset),
    .data      (bus.received_data),
    .data_en   (bus.received_data_en),
    .code_valid(code_valid),
    .code      (dec_code),
    .is_ext    (dec_ext),
    .is_break  (dec_break),
    .overflow  (overflow),
    .seq_error (dec_error)
  );

  // Every table entry whose code and ext flag match the current code
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      match[i] = (dec_code == KEY_CODES[i*8 +: 8]) && (dec_ext == KEY_EXT[i]);
    end
  end

  // Edge detection on held state; repeats and stray breaks fall out naturally
  always_comb begin
    press_nxt   = '0;
    release_nxt = '0;
    if (code_valid) begin
      if (dec_break) release_nxt = match & held_q;
      else           press_nxt   = match & ~held_q;
    end else if (overflow) begin
      release_nxt = held_q;
    end
    held_nxt = (held_q | press_nxt) & ~release_nxt;
  end

  // Single output register stage
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      held_q       <= '0;
      press_q      <= '0;
      release_q    <= '0;
      last_code_q  <= 8'h00;
      last_ext_q   <= 1'b0;
      last_break_q <= 1'b0;
      seq_error_q  <= 1'b0;
    end else begin
      held_q      <= held_nxt;
      press_q     <= press_nxt;
      release_q   <= release_nxt;
      seq_error_q <= dec_error;
      if (code_valid) begin
        last_code_q  <= dec_code;
        last_ext_q   <= dec_ext;
        last_break_q <= dec_break;
      end
    end
  end

  assign bus.key_held    = held_q;
  assign bus.key_press   = press_q;
  assign bus.key_release = release_q;
  assign bus.any_held    = |held_q;
  assign bus.last_code   = last_code_q;
  assign bus.last_ext    = last_ext_q;
  assign bus.last_break  = last_break_q;
  assign bus.seq_error   = seq_error_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: default key table on dut_a, an
// extended-key table on dut_b, both with a short prefix timeout.
module tb_ps2_key_tracker;
  import ps2_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  ps2_key_if #(.NUM_KEYS(4)) ifa ();
  ps2_key_if #(.NUM_KEYS(4)) ifb ();

  ps2_key_tracker #(
    .NUM_KEYS      (4),
    .TIMEOUT_CYCLES(16)
  ) dut_a (
    .CLOCK_50(clk),
    .reset   (rst),
    .bus     (ifa)
  );

  ps2_key_tracker #(
    .NUM_KEYS      (4),
    .KEY_CODES     ({KEY_SPACE, KEY_P, KEY_S, 8'h75}),
    .KEY_EXT       (4'b0001),
    .TIMEOUT_CYCLES(16)
  ) dut_b (
    .CLOCK_50(clk),
    .reset   (rst),
    .bus     (ifb)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [3:0] held, input logic [3:0] press,
                       input logic [3:0] rel);
    chk({tag, ".held"},    16'(ifa.key_held),    16'(held));
    chk({tag, ".press"},   16'(ifa.key_press),   16'(press));
    chk({tag, ".release"}, 16'(ifa.key_release), 16'(rel));
  endtask

  task automatic chk_b(input string tag, input logic [3:0] held, input logic [3:0] press,
                       input logic [3:0] rel);
    chk({tag, ".held"},    16'(ifb.key_held),    16'(held));
    chk({tag, ".press"},   16'(ifb.key_press),   16'(press));
    chk({tag, ".release"}, 16'(ifb.key_release), 16'(rel));
  endtask

  // Called at a negedge; returns at the next negedge, just after the capture edge
  task automatic sa(input logic [7:0] b);
    ifa.received_data    = b;
    ifa.received_data_en = 1'b1;
    @(negedge clk);
    ifa.received_data_en = 1'b0;
  endtask

  task automatic sb(input logic [7:0] b);
    ifb.received_data    = b;
    ifb.received_data_en = 1'b1;
    @(negedge clk);
    ifb.received_data_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ifa.received_data    = 8'h00;
    ifa.received_data_en = 1'b0;
    ifb.received_data    = 8'h00;
    ifb.received_data_en = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    chk_a("rst", 4'b0000, 4'b0000, 4'b0000);
    chk("rst.any_held",   16'(ifa.any_held),   16'h0);
    chk("rst.last_code",  16'(ifa.last_code),  16'h00);
    chk("rst.last_ext",   16'(ifa.last_ext),   16'h0);
    chk("rst.last_break", 16'(ifa.last_break), 16'h0);
    chk("rst.seq_error",  16'(ifa.seq_error),  16'h0);
    chk_b("rst_b", 4'b0000, 4'b0000, 4'b0000);
    rst = 1'b0;
    @(negedge clk);

    // W make, typematic repeat, break
    sa(8'h1D);
    chk_a("w_make", 4'b0001, 4'b0001, 4'b0000);
    chk("w_make.any_held",  16'(ifa.any_held),  16'h1);
    chk("w_make.last_code", 16'(ifa.last_code), 16'h1D);
    @(negedge clk);
    chk_a("w_make_end", 4'b0001, 4'b0000, 4'b0000);
    sa(8'h1D);
    chk_a("w_repeat", 4'b0001, 4'b0000, 4'b0000);
    sa(8'hF0);
    chk_a("w_prefix", 4'b0001, 4'b0000, 4'b0000);
    sa(8'h1D);
    chk_a("w_break", 4'b0000, 4'b0000, 4'b0001);
    chk("w_break.last_break", 16'(ifa.last_break), 16'h1);
    chk("w_break.any_held",   16'(ifa.any_held),   16'h0);
    @(negedge clk);
    chk_a("w_break_end", 4'b0000, 4'b0000, 4'b0000);

    // W and S held, then keyboard overflow
    sa(8'h1D);
    chk_a("ovf_w", 4'b0001, 4'b0001, 4'b0000);
    sa(8'h1B);
    chk_a("ovf_s", 4'b0011, 4'b0010, 4'b0000);
    sa(8'h00);
    chk_a("ovf", 4'b0000, 4'b0000, 4'b0011);
    chk("ovf.any_held",   16'(ifa.any_held),   16'h0);
    chk("ovf.last_code",  16'(ifa.last_code),  16'h1B);
    chk("ovf.last_break", 16'(ifa.last_break), 16'h0);
    @(negedge clk);
    chk_a("ovf_end", 4'b0000, 4'b0000, 4'b0000);

    // Prefix timeout: F0 at edge N, error registered at edge N+16
    sa(8'hF0);
    repeat (15) @(negedge clk);
    chk("to_early.seq_error", 16'(ifa.seq_error), 16'h0);
    @(negedge clk);
    chk("to_fire.seq_error", 16'(ifa.seq_error), 16'h1);
    @(negedge clk);
    chk("to_end.seq_error", 16'(ifa.seq_error), 16'h0);
    sa(8'h1B);
    chk_a("to_make_s", 4'b0010, 4'b0010, 4'b0000);
    chk("to_make_s.last_break", 16'(ifa.last_break), 16'h0);

    // Byte on the expiry cycle wins and is decoded as a break
    sa(8'hF0);
    repeat (15) @(negedge clk);
    sa(8'h1B);
    chk_a("to_race", 4'b0000, 4'b0000, 4'b0010);
    chk("to_race.seq_error",  16'(ifa.seq_error),  16'h0);
    chk("to_race.last_break", 16'(ifa.last_break), 16'h1);
    @(negedge clk);
    chk("to_race_after.seq_error", 16'(ifa.seq_error), 16'h0);

    // E0 E0 1D: error on second prefix, then extended make (untracked)
    sa(8'hE0);
    chk("e0e0_first.seq_error", 16'(ifa.seq_error), 16'h0);
    sa(8'hE0);
    chk("e0e0_second.seq_error", 16'(ifa.seq_error), 16'h1);
    sa(8'h1D);
    chk_a("e0e0_code", 4'b0000, 4'b0000, 4'b0000);
    chk("e0e0_code.seq_error",  16'(ifa.seq_error),  16'h0);
    chk("e0e0_code.last_code",  16'(ifa.last_code),  16'h1D);
    chk("e0e0_code.last_ext",   16'(ifa.last_ext),   16'h1);
    chk("e0e0_code.last_break", 16'(ifa.last_break), 16'h0);

    // F0 F0 1D with W held: error on second prefix, then break
    sa(8'h1D);
    chk_a("f0f0_w", 4'b0001, 4'b0001, 4'b0000);
    chk("f0f0_w.last_ext", 16'(ifa.last_ext), 16'h0);
    sa(8'hF0);
    sa(8'hF0);
    chk("f0f0_second.seq_error", 16'(ifa.seq_error), 16'h1);
    sa(8'h1D);
    chk_a("f0f0_code", 4'b0000, 4'b0000, 4'b0001);
    chk("f0f0_code.last_break", 16'(ifa.last_break), 16'h1);
    chk("f0f0_code.last_ext",   16'(ifa.last_ext),   16'h0);
    chk("f0f0_code.seq_error",  16'(ifa.seq_error),  16'h0);

    // Status bytes are ignored and leave the sequencer in IDLE
    sa(PS2_ACK);
    chk("ack.last_code", 16'(ifa.last_code), 16'h1D);
    chk_a("ack", 4'b0000, 4'b0000, 4'b0000);
    sa(PS2_BAT);
    sa(8'h1D);
    chk_a("after_status", 4'b0001, 4'b0001, 4'b0000);

    // Reset between F0 and 1D with W held
    sa(8'hF0);
    rst = 1'b1;
    #1;
    chk_a("mid_rst", 4'b0000, 4'b0000, 4'b0000);
    chk("mid_rst.last_code", 16'(ifa.last_code), 16'h00);
    chk("mid_rst.seq_error", 16'(ifa.seq_error), 16'h0);
    @(negedge clk);
    rst = 1'b0;
    sa(8'h1D);
    chk_a("post_rst", 4'b0001, 4'b0001, 4'b0000);
    chk("post_rst.last_break", 16'(ifa.last_break), 16'h0);

    // Extended-only key 0 on dut_b
    sb(8'h75);
    chk_b("ext_plain", 4'b0000, 4'b0000, 4'b0000);
    chk("ext_plain.last_code", 16'(ifb.last_code), 16'h75);
    chk("ext_plain.last_ext",  16'(ifb.last_ext),  16'h0);
    sb(8'hE0);
    sb(8'h75);
    chk_b("ext_make", 4'b0001, 4'b0001, 4'b0000);
    chk("ext_make.last_ext", 16'(ifb.last_ext), 16'h1);
    sb(8'hE0);
    sb(8'hF0);
    sb(8'h75);
    chk_b("ext_break", 4'b0000, 4'b0000, 4'b0001);
    chk("ext_break.last_ext",   16'(ifb.last_ext),   16'h1);
    chk("ext_break.last_break", 16'(ifb.last_break), 16'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_key_tracker.md
# ps2_key_tracker

Parametrised PS/2 scancode-set-2 key tracker between `PS2_Controller` and game logic. Consumes the controller's received-byte stream and decodes make/break (`F0`) and extended (`E0`) prefixes. Holds a per-key pressed state for a configurable table of keys and emits one-cycle press/release pulses with typematic repeats suppressed. Successor to the single-key start/up/down decoding; supports N keys, extended keys, prefix timeout and keyboard-overflow recovery.

## Interface
- `NUM_KEYS`, 4: number of tracked keys, 1..16.
- `KEY_CODES`, {8'h29, 8'h4D, 8'h1B, 8'h1D}: NUM_KEYS×8 packed; byte i = code of key i (default: 0 W, 1 S, 2 P, 3 Space).
- `KEY_EXT`, 4'b0000: bit i = 1 means key i is matched only when `E0`-prefixed.
- `TIMEOUT_CYCLES`, 1_000_000: max gap between a prefix and the next byte (20 ms at 50 MHz), ≥ 2.
- `CLOCK_50`  in  1  system clock; all logic rises on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `received_data`  in  8  byte from `PS2_Controller`.
- `received_data_en`  in  1  one-cycle strobe; `received_data` is valid this cycle.
- `key_held`  out  NUM_KEYS  level; bit i = key i currently down.
- `key_press`  out  NUM_KEYS  one-cycle pulse on key i's up→down transition.
- `key_release`  out  NUM_KEYS  one-cycle pulse on key i's down→up transition.
- `any_held`  out  1  OR of `key_held`.
- `last_code`  out  8  last completed code byte (tracked or not).
- `last_ext`  out  1  `E0` flag of `last_code`.
- `last_break`  out  1  break flag of `last_code`.
- `seq_error`  out  1  one-cycle pulse on a protocol error or timeout.

## Operation
- Sequence FSM states: IDLE, EXT (after `E0`), BRK (after `F0`), EXT_BRK (after `E0 F0`). Advances only on `received_data_en`.
- IDLE: `E0`→EXT; `F0`→BRK; `FA`, `AA`, `EE`, `FE` ignored, no state change; `00`/`FF` = overflow (below); any other byte = make code, ext=0.
- EXT: `F0`→EXT_BRK; other byte = make, ext=1 → IDLE.
- BRK / EXT_BRK: non-prefix byte = break, ext = 0 / 1 → IDLE.
- Errors, each pulsing `seq_error`:
  - `E0` in any non-IDLE state → EXT.
  - `F0` in BRK or EXT_BRK → stay.
- Completed code: `last_code`, `last_ext` and `last_break` update. Key i matches when code == byte i and ext == `KEY_EXT[i]`; all matching keys act together.
  - Make on a not-held key: set held and pulse `key_press`.
  - Make on a held key (typematic repeat): no pulse.
  - Break on a held key: clear held and pulse `key_release`.
  - Break on a not-held key: ignored.
- Overflow (`00`/`FF` in IDLE): all held keys clear; `key_release` pulses for exactly those bits. `last_*` unchanged.
- Timeout: a counter runs while not IDLE and clears on every accepted byte. At `TIMEOUT_CYCLES-1` the FSM → IDLE and `seq_error` pulses. Held state is unchanged.

## Timing
- Reset values:
  - FSM: IDLE, timeout counter 0.
  - Outputs: `key_held`, `key_press`, `key_release`, `any_held`, `seq_error` all 0; `last_code` 8'h00; `last_ext` 0; `last_break` 0.
- Latency: strobe sampled at edge N → all outputs reflect it after edge N (one register stage). Pulses are high for exactly cycle N+1.
- Throughput: back-to-back strobes on consecutive cycles are fully accepted.
- A strobe in the same cycle as timeout expiry: the byte wins; it is decoded in the current state and the counter clears.
- Reset asserted mid-sequence: everything clears immediately, no pulses. A partial sequence is discarded.

## Structure
- Package `ps2_pkg`:
  - Constants `PS2_EXT` 8'hE0, `PS2_BRK` 8'hF0, `PS2_ACK` 8'hFA, `PS2_BAT` 8'hAA, `PS2_ECHO` 8'hEE, `PS2_RESEND` 8'hFE, `PS2_OVF0` 8'h00, `PS2_OVF1` 8'hFF.
  - Default letter codes W/A/S/D/P/Space.
  - FSM state typedef.
- Sub-module `ps2_seq_decoder`: FSM plus timeout counter. Outputs a one-cycle `code_valid`, `code`, `is_ext`, `is_break`, `overflow`, `seq_error`.
- Top level: key table match, held registers, pulse generation.

## Test plan
- Strobes `1D`, `1D`, `F0 1D` → `key_held[0]` 1 then 0; a single `key_press[0]` pulse after the first `1D`; no pulse for the repeat; a single `key_release[0]`.
- With `KEY_EXT`=4'b0001 and KEY_CODES byte0=8'h75:
  - `75` → no effect.
  - `E0 75` → `key_press[0]`.
  - `E0 F0 75` → `key_release[0]`; `last_ext`=1, `last_break`=1.
- W and S held, then `00` → `key_release`=4'b0011 in one cycle, `any_held`=0.
- `F0`, then idle for `TIMEOUT_CYCLES` → `seq_error` pulse; a following `1B` is a make (`key_press[1]`).
- `E0 E0 1D` and `F0 F0 1D` → `seq_error` pulse at the second prefix; the final byte decodes as ext make and as break respectively.
- Reset asserted between `F0` and `1D` while W is held → all cleared; post-reset `1D` → `key_press[0]`.
